// File: rtl/calc_scheduler.sv
// Round-robin front end for the shared +/-/x calculator core: grants one of two
// requesters, holds registered operands on the core, captures and returns the tagged result.
module calc_scheduler #(
  parameter int CORE_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [2:0]       req0_n0,
  input  logic [2:0]       req0_n1,
  input  logic [2:0]       req1_n0,
  input  logic [2:0]       req1_n1,
  input  logic [1:0]       req0_opt,
  input  logic [1:0]       req1_opt,
  output logic [2:0]       core_n0,
  output logic [2:0]       core_n1,
  output logic [1:0]       core_opt,
  input  logic [6:0]       core_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [6:0]       res_data,
  output logic [CNT_W-1:0] done_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] LAT_M1 = 3'(CORE_LAT - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_rr;
  logic             r_op_id;
  logic [2:0]       r_cnt;
  logic [2:0]       r_core_n0;
  logic [2:0]       r_core_n1;
  logic [1:0]       r_core_opt;
  logic             r_res_valid;
  logic             r_res_id;
  logic [6:0]       r_res_data;
  logic [CNT_W-1:0] r_done_cnt;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_idle;
  logic             w_hs;

  // A lone valid requester always wins; on contention the pointer decides.
  assign w_grant0   = req0_valid & (~req1_valid | ~r_rr);
  assign w_grant1   = req1_valid & (~req0_valid |  r_rr);
  assign w_idle     = (r_state == IDLE);
  assign req0_ready = w_idle & w_grant0;
  assign req1_ready = w_idle & w_grant1;
  assign w_hs       = req0_ready | req1_ready;

  assign core_n0    = r_core_n0;
  assign core_n1    = r_core_n1;
  assign core_opt   = r_core_opt;
  assign res_valid  = r_res_valid;
  assign res_id     = r_res_id;
  assign res_data   = r_res_data;
  assign done_cnt   = r_done_cnt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_hs) w_next_state = EXEC;
        else      w_next_state = IDLE;
      end
      EXEC: begin
        if (r_cnt == 3'd0) w_next_state = RESP;
        else               w_next_state = EXEC;
      end
      RESP: begin
        if (res_ready) w_next_state = IDLE;
        else           w_next_state = RESP;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Operand, settle-counter, result and completion-counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr        <= 1'b0;
      r_op_id     <= 1'b0;
      r_cnt       <= 3'd0;
      r_core_n0   <= 3'd0;
      r_core_n1   <= 3'd0;
      r_core_opt  <= 2'd0;
      r_res_valid <= 1'b0;
      r_res_id    <= 1'b0;
      r_res_data  <= 7'd0;
      r_done_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_core_n0  <= w_grant1 ? req1_n0  : req0_n0;
            r_core_n1  <= w_grant1 ? req1_n1  : req0_n1;
            r_core_opt <= w_grant1 ? req1_opt : req0_opt;
            r_op_id    <= w_grant1;
            r_rr       <= ~w_grant1;
            r_cnt      <= LAT_M1;
          end
        end
        EXEC: begin
          // Operands have been on the core for CORE_LAT cycles at this point.
          if (r_cnt == 3'd0) begin
            r_res_data  <= core_out;
            r_res_id    <= r_op_id;
            r_res_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_done_cnt  <= r_done_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_calc_scheduler.sv
// Directed bench for calc_scheduler: a CORE_LAT=1 instance driving a real
// calculator model, and a CORE_LAT=3 / CNT_W=4 instance driving a counting stub.
module tb_calc_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid, res_ready;
  logic [2:0] req0_n0, req0_n1, req1_n0, req1_n1;
  logic [1:0] req0_opt, req1_opt;

  logic        req0_ready, req1_ready, res_valid, res_id;
  logic [2:0]  core_n0, core_n1;
  logic [1:0]  core_opt;
  logic [6:0]  core_out, res_data;
  logic [15:0] done_cnt;

  logic        req0_ready2, req1_ready2, res_valid2, res_id2;
  logic [2:0]  core2_n0, core2_n1;
  logic [1:0]  core2_opt;
  logic [6:0]  res_data2;
  logic [3:0]  done_cnt2;
  logic [6:0]  stub_cnt = 7'd0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) stub_cnt <= stub_cnt + 7'd1;

  always_comb begin
    case (core_opt)
      2'b00:   core_out = {4'd0, core_n0} + {4'd0, core_n1};
      2'b01:   core_out = {4'd0, core_n0} - {4'd0, core_n1};
      2'b10:   core_out = {4'd0, core_n0} * {4'd0, core_n1};
      default: core_out = 7'h55;
    endcase
  end

  calc_scheduler #(.CORE_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_n0(req0_n0), .req0_n1(req0_n1), .req1_n0(req1_n0), .req1_n1(req1_n1),
    .req0_opt(req0_opt), .req1_opt(req1_opt),
    .core_n0(core_n0), .core_n1(core_n1), .core_opt(core_opt), .core_out(core_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_data(res_data), .done_cnt(done_cnt)
  );

  calc_scheduler #(.CORE_LAT(3), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready2), .req1_ready(req1_ready2),
    .req0_n0(req0_n0), .req0_n1(req0_n1), .req1_n0(req1_n0), .req1_n1(req1_n1),
    .req0_opt(req0_opt), .req1_opt(req1_opt),
    .core_n0(core2_n0), .core_n1(core2_n1), .core_opt(core2_opt), .core_out(stub_cnt),
    .res_valid(res_valid2), .res_ready(res_ready), .res_id(res_id2),
    .res_data(res_data2), .done_cnt(done_cnt2)
  );

  task automatic do_reset;
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    req0_n0 = 3'd5; req0_n1 = 3'd6; req0_opt = 2'b10;
    req1_n0 = 3'd1; req1_n1 = 3'd2; req1_opt = 2'b01;
    @(negedge clk); #1;
    n_checks++; if ({core_n0, core_n1, core_opt} !== 8'd0) begin n_errors++; $display("FAIL reset_core got %0h exp 0", {core_n0, core_n1, core_opt}); end
    n_checks++; if ({res_valid, res_id, res_data} !== 9'd0) begin n_errors++; $display("FAIL reset_res got %0h exp 0", {res_valid, res_id, res_data}); end
    n_checks++; if (done_cnt !== 16'd0) begin n_errors++; $display("FAIL reset_cnt got %0d exp 0", done_cnt); end
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_errors++; $display("FAIL reset_ready got %b exp 10", {req0_ready, req1_ready}); end
    n_checks++; if ({res_valid2, done_cnt2, core2_n0} !== 8'd0) begin n_errors++; $display("FAIL reset_dut2 got %0h exp 0", {res_valid2, done_cnt2, core2_n0}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_basic;
    do_reset();
    req0_n0 = 3'd3; req0_n1 = 3'd4; req0_opt = 2'b00; req0_valid = 1'b1; res_ready = 1'b1;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b10) begin n_errors++; $display("FAIL basic_ready got %b exp 10", {req0_ready, req1_ready}); end
    @(posedge clk); #1; req0_valid = 1'b0;
    n_checks++; if ({res_valid, core_n0, core_n1, core_opt} !== {1'b0, 3'd3, 3'd4, 2'b00}) begin n_errors++; $display("FAIL basic_exec got %0h exp %0h", {res_valid, core_n0, core_n1, core_opt}, {1'b0, 3'd3, 3'd4, 2'b00}); end
    @(posedge clk); #1;
    n_checks++; if ({res_valid, res_id, res_data} !== {1'b1, 1'b0, 7'd7}) begin n_errors++; $display("FAIL basic_result got %0h exp %0h", {res_valid, res_id, res_data}, {1'b1, 1'b0, 7'd7}); end
    n_checks++; if (done_cnt !== 16'd0) begin n_errors++; $display("FAIL basic_cnt_before got %0d exp 0", done_cnt); end
    @(posedge clk); #1;
    n_checks++; if ({res_valid, done_cnt} !== {1'b0, 16'd1}) begin n_errors++; $display("FAIL basic_done got %0h exp %0h", {res_valid, done_cnt}, {1'b0, 16'd1}); end
  endtask

  task automatic test_reserved;
    do_reset();
    req1_n0 = 3'd0; req1_n1 = 3'd0; req1_opt = 2'b11; req1_valid = 1'b1; res_ready = 1'b1;
    #1;
    n_checks++; if ({req0_ready, req1_ready} !== 2'b01) begin n_errors++; $display("FAIL resv_ready got %b exp 01", {req0_ready, req1_ready}); end
    @(posedge clk); #1; req1_valid = 1'b0;
    n_checks++; if (core_opt !== 2'b11) begin n_errors++; $display("FAIL resv_opt got %b exp 11", core_opt); end
    @(posedge clk); #1;
    n_checks++; if ({res_valid, res_id, res_data} !== {1'b1, 1'b1, 7'h55}) begin n_errors++; $display("FAIL resv_result got %0h exp %0h", {res_valid, res_id, res_data}, {1'b1, 1'b1, 7'h55}); end
  endtask

  task automatic test_round_robin;
    int ng = 0;
    int nr = 0;
    do_reset();
    req0_n0 = 3'd7; req0_n1 = 3'd7; req0_opt = 2'b10; req0_valid = 1'b1;
    req1_n0 = 3'd2; req1_n1 = 3'd5; req1_opt = 2'b01; req1_valid = 1'b1;
    res_ready = 1'b1;
    #1;
    for (int c = 0; c < 20; c++) begin
      n_checks++; if (req0_ready & req1_ready) begin n_errors++; $display("FAIL rr_both_ready cycle %0d got 11 exp not 11", c); end
      if (req0_ready | req1_ready) begin
        n_checks++; if (req1_ready !== ng[0]) begin n_errors++; $display("FAIL rr_grant #%0d got id %0d exp id %0d", ng, req1_ready, ng[0]); end
        ng++;
      end
      if (res_valid) begin
        n_checks++; if ({res_id, res_data} !== {nr[0], (nr[0] ? 7'h7D : 7'd49)}) begin n_errors++; $display("FAIL rr_result #%0d got %0h exp %0h", nr, {res_id, res_data}, {nr[0], (nr[0] ? 7'h7D : 7'd49)}); end
        nr++;
      end
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    n_checks++; if (ng < 6 || nr < 6) begin n_errors++; $display("FAIL rr_throughput got %0d grants %0d results exp >=6 each", ng, nr); end
  endtask

  task automatic test_backpressure;
    do_reset();
    req0_n0 = 3'd1; req0_n1 = 3'd5; req0_opt = 2'b00; req0_valid = 1'b1;
    req1_n0 = 3'd4; req1_n1 = 3'd4; req1_opt = 2'b10;
    res_ready = 1'b0;
    @(posedge clk); #1; req1_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      n_checks++; if ({res_valid, res_id, res_data} !== {1'b1, 1'b0, 7'd6}) begin n_errors++; $display("FAIL bp_hold cycle %0d got %0h exp %0h", c, {res_valid, res_id, res_data}, {1'b1, 1'b0, 7'd6}); end
      n_checks++; if ({req0_ready, req1_ready} !== 2'b00) begin n_errors++; $display("FAIL bp_ready cycle %0d got %b exp 00", c, {req0_ready, req1_ready}); end
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({res_valid, req0_ready, req1_ready} !== 3'b001) begin n_errors++; $display("FAIL bp_release got %b exp 001", {res_valid, req0_ready, req1_ready}); end
    n_checks++; if (done_cnt !== 16'd1) begin n_errors++; $display("FAIL bp_cnt got %0d exp 1", done_cnt); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_core_lat3;
    logic [6:0] c0;
    do_reset();
    req0_n0 = 3'd3; req0_n1 = 3'd3; req0_opt = 2'b00; req0_valid = 1'b1; res_ready = 1'b1;
    #1;
    n_checks++; if (req0_ready2 !== 1'b1) begin n_errors++; $display("FAIL lat3_ready got %b exp 1", req0_ready2); end
    c0 = stub_cnt;
    @(posedge clk); #1; req0_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++; if ({res_valid2, core2_n0, core2_n1, core2_opt} !== {1'b0, 3'd3, 3'd3, 2'b00}) begin n_errors++; $display("FAIL lat3_exec cycle %0d got %0h exp %0h", c, {res_valid2, core2_n0, core2_n1, core2_opt}, {1'b0, 3'd3, 3'd3, 2'b00}); end
      @(posedge clk); #1;
    end
    n_checks++; if ({res_valid2, res_id2, res_data2} !== {1'b1, 1'b0, 7'(c0 + 7'd3)}) begin n_errors++; $display("FAIL lat3_capture got %0h exp %0h", {res_valid2, res_id2, res_data2}, {1'b1, 1'b0, 7'(c0 + 7'd3)}); end
  endtask

  task automatic test_reset_mid_exec;
    do_reset();
    req0_n0 = 3'd3; req0_n1 = 3'd3; req0_opt = 2'b00; req0_valid = 1'b1;
    req1_n0 = 3'd3; req1_n1 = 3'd3; req1_opt = 2'b00; req1_valid = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1; req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    n_checks++; if ({res_valid2, res_id2, res_data2, core2_n0, core2_n1, core2_opt, done_cnt2} !== 21'd0) begin n_errors++; $display("FAIL midrst_outputs got %0h exp 0", {res_valid2, res_id2, res_data2, core2_n0, core2_n1, core2_opt, done_cnt2}); end
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      n_checks++; if (res_valid2 !== 1'b0) begin n_errors++; $display("FAIL midrst_ghost cycle %0d got 1 exp 0", c); end
    end
    n_checks++; if (done_cnt2 !== 4'd0) begin n_errors++; $display("FAIL midrst_cnt got %0d exp 0", done_cnt2); end
    req0_valid = 1'b1; req1_valid = 1'b1; #1;
    n_checks++; if ({req0_ready2, req1_ready2} !== 2'b10) begin n_errors++; $display("FAIL midrst_rr got %b exp 10", {req0_ready2, req1_ready2}); end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_wrap;
    int n = 0;
    int c = 0;
    do_reset();
    req0_n0 = 3'd1; req0_n1 = 3'd1; req0_opt = 2'b00; req0_valid = 1'b1; res_ready = 1'b1;
    #1;
    while (n < 16 && c < 200) begin
      if (res_valid2) begin
        n++;
        @(posedge clk); #1; c++;
        n_checks++; if (done_cnt2 !== 4'(n)) begin n_errors++; $display("FAIL wrap_cnt #%0d got %0d exp %0d", n, done_cnt2, 4'(n)); end
      end else begin
        @(posedge clk); #1; c++;
      end
    end
    req0_valid = 1'b0;
    n_checks++; if (n != 16) begin n_errors++; $display("FAIL wrap_timeout got %0d results exp 16", n); end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_reserved();
    test_round_robin();
    test_backpressure();
    test_core_lat3();
    test_reset_mid_exec();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
